// File: rtl/bus_pkg.sv
// Shared definitions for the BIU bus handshake (cs_biu / sel_biu / ready_bus).
// Used by the bus interface unit side and by the memory-side responder so that
// the operation encodings and the word width are consistent between the two.
//   WORD_W        : bus data word width
//   sel_e         : sel_biu operation encodings
//   resp_state_e  : responder FSM states
//   WAIT_W        : width of the wait-state counter (0..15 wait states)
package bus_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        SEL_FETCH = 2'b00,
        SEL_RD    = 2'b01,
        SEL_WR    = 2'b10,
        SEL_RSV   = 2'b11
    } sel_e;

    // StLatch is the cycle in which registered RAM read data is visible and
    // gets copied into rdata/ir on the edge that enters StAck.
    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccess,
        StBeat2,
        StLatch,
        StAck,
        StRelease
    } resp_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x WORD_W, one read or one write per cycle.
// Read data is registered: it appears in the cycle after the read request.
// Contents are not reset.
//   clk_i   : clock
//   req_i   : access request for this cycle
//   we_i    : 1 = write wdata_i to idx_i, 0 = read idx_i
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data (holds between reads)
module mem_array
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the BIU bus handshake. Accepts a request when
// cs_biu_i is high in IDLE, inserts WAIT_CYCLES wait states, performs a data
// read, data write or two-beat 32-bit instruction fetch on mem_array, pulses
// ready_bus_o for one cycle, then waits for cs_biu_i to drop (four-phase).
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   cs_biu_i    : request strobe, held by the initiator until ready_bus_o
//   sel_biu_i   : 00 fetch, 01 data read, 10 data write, 11 reserved
//   addr_i      : word address, sampled at accept
//   wdata_i     : write data, sampled at accept
//   rdata_o     : data-read result
//   ir_o        : fetch result {mem[addr], mem[addr+1]}
//   ready_bus_o : one-cycle completion pulse
//   err_o       : high with ready_bus_o for a reserved operation
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cs_biu_i,
    input  logic [1:0]          sel_biu_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [WORD_W-1:0]   rdata_o,
    output logic [2*WORD_W-1:0] ir_o,
    output logic                ready_bus_o,
    output logic                err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Counter is loaded with WAIT_CYCLES-1 so StWait lasts exactly WAIT_CYCLES cycles.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

    resp_state_e         state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    sel_e                op_q, op_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [2*WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0]   hi_q, hi_d;

    logic                mem_req;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic [WORD_W-1:0]   mem_rdata;

    // Address bits above the memory index are ignored: addresses wrap.
    if (IDX_W < ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W];
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (clk_i),
        .req_i   (mem_req),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= SEL_FETCH;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ir_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ir_q    <= ir_d;
            hi_q    <= hi_d;
        end
    end

    // Memory port: first word (or write) in StAccess, second fetch word in StBeat2.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_idx = idx_q;
        unique case (state_q)
            StAccess: begin
                mem_req = (op_q != SEL_RSV);
                mem_we  = (op_q == SEL_WR);
            end
            StBeat2: begin
                mem_req = 1'b1;
                mem_idx = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ir_d    = ir_q;
        hi_d    = hi_q;
        unique case (state_q)
            StIdle: begin
                if (cs_biu_i) begin
                    op_d    = sel_e'(sel_biu_i);
                    idx_d   = addr_i[IDX_W-1:0];
                    wdata_d = wdata_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            StAccess: begin
                state_d = (op_q == SEL_FETCH) ? StBeat2 : StLatch;
            end
            StBeat2: begin
                hi_d    = mem_rdata;
                state_d = StLatch;
            end
            StLatch: begin
                if (op_q == SEL_RD) begin
                    rdata_d = mem_rdata;
                end
                if (op_q == SEL_FETCH) begin
                    ir_d = {hi_q, mem_rdata};
                end
                state_d = StAck;
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                // A strobe still held after the ack must not start a new access.
                if (!cs_biu_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rdata_o     = rdata_q;
    assign ir_o        = ir_q;
    assign ready_bus_o = (state_q == StAck);
    assign err_o       = (state_q == StAck) && (op_q == SEL_RSV);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: one instance with WAIT_CYCLES=2 (side a) driven
// from a vector table plus hand sequences, one with WAIT_CYCLES=0 (side b).
module tb_bus_mem_responder;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cs_a = 1'b0, cs_b = 1'b0;
    logic [1:0]  sel_a = 2'b00, sel_b = 2'b00;
    logic [15:0] addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic [15:0] rdata_a, rdata_b;
    logic [31:0] ir_a, ir_b;
    logic        rdy_a, rdy_b, err_a, err_b;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          err_glitch = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .ADDR_W      (16),
        .DEPTH       (256),
        .WAIT_CYCLES (2)
    ) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cs_biu_i    (cs_a),
        .sel_biu_i   (sel_a),
        .addr_i      (addr_a),
        .wdata_i     (wdata_a),
        .rdata_o     (rdata_a),
        .ir_o        (ir_a),
        .ready_bus_o (rdy_a),
        .err_o       (err_a)
    );

    bus_mem_responder #(
        .ADDR_W      (16),
        .DEPTH       (256),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cs_biu_i    (cs_b),
        .sel_biu_i   (sel_b),
        .addr_i      (addr_b),
        .wdata_i     (wdata_b),
        .rdata_o     (rdata_b),
        .ir_o        (ir_b),
        .ready_bus_o (rdy_b),
        .err_o       (err_b)
    );

    // err must never be high outside the ack cycle.
    always @(negedge clk) begin
        if (rst_n && ((err_a && !rdy_a) || (err_b && !rdy_b))) begin
            err_glitch = err_glitch + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic        err;
        logic [15:0] rdata;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end else begin
            pass_cnt = pass_cnt + 1;
        end
    endtask

    task automatic drive(input bit z, input logic cs, input logic [1:0] s,
                         input logic [15:0] a, input logic [15:0] d);
        if (!z) begin
            cs_a = cs; sel_a = s; addr_a = a; wdata_a = d;
        end else begin
            cs_b = cs; sel_b = s; addr_b = a; wdata_b = d;
        end
    endtask

    function automatic logic rdy_of(input bit z);
        return z ? rdy_b : rdy_a;
    endfunction

    function automatic logic err_of(input bit z);
        return z ? err_b : err_a;
    endfunction

    // lat = number of edges after the accept edge A at which ready was seen
    // high in the following cycle; -1 if no ack within the budget.
    task automatic run_txn(input bit z, input string nm, input logic [1:0] s,
                           input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic e);
        lat = -1;
        e   = 1'b0;
        @(posedge clk); #1;
        drive(z, 1'b1, s, a, d);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(z, 1'b1, ~s, ~a, ~d);
            if (rdy_of(z)) begin
                lat = k - 1;
                e   = err_of(z);
                break;
            end
        end
        drive(z, 1'b0, s, a, d);
        @(posedge clk); #1;
        chk({nm, "_one_cycle"}, {31'b0, rdy_of(z)}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   lat;
        logic e;
        int   pulses;

        vecs[0]  = '{2'b10, 16'd5,      16'hBEEF, 4, 1'b0, 16'h0000, 32'h0000_0000};
        vecs[1]  = '{2'b01, 16'd5,      16'h0000, 4, 1'b0, 16'hBEEF, 32'h0000_0000};
        vecs[2]  = '{2'b10, 16'd255,    16'h1234, 4, 1'b0, 16'hBEEF, 32'h0000_0000};
        vecs[3]  = '{2'b10, 16'd0,      16'h5678, 4, 1'b0, 16'hBEEF, 32'h0000_0000};
        vecs[4]  = '{2'b00, 16'd255,    16'h0000, 5, 1'b0, 16'hBEEF, 32'h1234_5678};
        vecs[5]  = '{2'b10, 16'd3,      16'hAAAA, 4, 1'b0, 16'hBEEF, 32'h1234_5678};
        vecs[6]  = '{2'b11, 16'd3,      16'h5555, 4, 1'b1, 16'hBEEF, 32'h1234_5678};
        vecs[7]  = '{2'b01, 16'd3,      16'h0000, 4, 1'b0, 16'hAAAA, 32'h1234_5678};
        vecs[8]  = '{2'b10, 16'd4,      16'h0A0B, 4, 1'b0, 16'hAAAA, 32'h1234_5678};
        vecs[9]  = '{2'b00, 16'd4,      16'h0000, 5, 1'b0, 16'hAAAA, 32'h0A0B_BEEF};
        vecs[10] = '{2'b10, 16'h0109,   16'hC0DE, 4, 1'b0, 16'hAAAA, 32'h0A0B_BEEF};
        vecs[11] = '{2'b01, 16'd9,      16'h0000, 4, 1'b0, 16'hC0DE, 32'h0A0B_BEEF};
        vecs[12] = '{2'b10, 16'd7,      16'h1111, 4, 1'b0, 16'hC0DE, 32'h0A0B_BEEF};
        vecs[13] = '{2'b01, 16'd7,      16'h0000, 4, 1'b0, 16'h1111, 32'h0A0B_BEEF};

        // Reset values.
        #12;
        chk("rst_rdy_a", {31'b0, rdy_a}, 32'd0);
        chk("rst_err_a", {31'b0, err_a}, 32'd0);
        chk("rst_rdata_a", {16'b0, rdata_a}, 32'd0);
        chk("rst_ir_a", ir_a, 32'd0);
        chk("rst_rdy_b", {31'b0, rdy_b}, 32'd0);
        chk("rst_rdata_b", {16'b0, rdata_b}, 32'd0);
        chk("rst_ir_b", ir_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table on the two-wait-state instance.
        for (int i = 0; i < 14; i++) begin
            run_txn(1'b0, $sformatf("v%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].wdata,
                    lat, e);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), {16'b0, rdata_a}, {16'b0, vecs[i].rdata});
            chk($sformatf("v%0d_ir", i), ir_a, vecs[i].ir);
        end

        // Zero wait states, back-to-back at minimum spacing.
        run_txn(1'b1, "z_wr5", 2'b10, 16'd5, 16'h1357, lat, e);
        chk("z_wr5_lat", lat, 2);
        run_txn(1'b1, "z_wr6", 2'b10, 16'd6, 16'h2468, lat, e);
        chk("z_wr6_lat", lat, 2);
        run_txn(1'b1, "z_rd5", 2'b01, 16'd5, 16'h0000, lat, e);
        chk("z_rd5_lat", lat, 2);
        chk("z_rd5_rdata", {16'b0, rdata_b}, 32'h0000_1357);
        run_txn(1'b1, "z_fe5", 2'b00, 16'd5, 16'h0000, lat, e);
        chk("z_fe5_lat", lat, 3);
        chk("z_fe5_ir", ir_b, 32'h1357_2468);
        chk("z_fe5_rdata", {16'b0, rdata_b}, 32'h0000_1357);

        // Held strobe: one ack, no retrigger while cs stays high.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2'b01, 16'd5, 16'h0000);
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (rdy_a) pulses = pulses + 1;
        end
        chk("held_pulses", pulses, 1);
        chk("held_rdata", {16'b0, rdata_a}, 32'h0000_BEEF);
        drive(1'b0, 1'b0, 2'b01, 16'd5, 16'h0000);
        @(posedge clk); #1;
        run_txn(1'b0, "after_held", 2'b01, 16'd3, 16'h0000, lat, e);
        chk("after_held_lat", lat, 4);
        chk("after_held_rdata", {16'b0, rdata_a}, 32'h0000_AAAA);

        // Reset during WAIT of a write to addr 7 (holds 16'h1111).
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2'b10, 16'd7, 16'h0F0F);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", {31'b0, rdy_a}, 32'd0);
        chk("midrst_err", {31'b0, err_a}, 32'd0);
        chk("midrst_rdata", {16'b0, rdata_a}, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rdy_a) pulses = pulses + 1;
        end
        chk("midrst_no_ack", pulses, 0);
        run_txn(1'b0, "midrst_rd7", 2'b01, 16'd7, 16'h0000, lat, e);
        chk("midrst_rd7_lat", lat, 4);
        chk("midrst_rd7_rdata", {16'b0, rdata_a}, 32'h0000_1111);

        // Strobe already high when reset releases: accepted on the first edge.
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 2'b01, 16'd5, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rdy_a) begin
                lat = k - 1;
                break;
            end
        end
        chk("relcs_lat", lat, 4);
        chk("relcs_rdata", {16'b0, rdata_a}, 32'h0000_BEEF);
        drive(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000);
        repeat (2) @(posedge clk);

        chk("err_only_with_ready", err_glitch, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the BIU bus handshake (`cs_biu` / `sel_biu` / `ready_bus`). It answers instruction fetches and data reads/writes issued by the bus interface unit from a single-port 16-bit word memory, with a programmable number of wait states. It sits below the BIU, the bus target that the fetch and execute units ultimately talk to, and drives the `ready_bus` that those units wait on.

## Interface
- `ADDR_W`, 16: address width in words.
- `DEPTH`, 256: memory words; power of two, at most 2^ADDR_W.
- `WAIT_CYCLES`, 2: wait states inserted before each access; legal range 0..15.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cs_biu` input 1: request strobe, held high by the initiator until it sees `ready_bus`.
- `sel_biu` input 2: operation. 00 fetch (32-bit), 01 data read, 10 data write, 11 reserved.
- `addr` input ADDR_W: word address, sampled at accept.
- `wdata` input 16: write data, sampled at accept.
- `rdata` output 16: data-read result.
- `ir` output 32: fetch result; `{mem[addr], mem[addr+1]}`.
- `ready_bus` output 1: one-cycle completion pulse.
- `err` output 1: high with `ready_bus` when the operation was reserved (`sel_biu` 11).

## Operation
- States:
  - IDLE: accept when `cs_biu`=1. Latch `sel_biu`, `addr`, `wdata`. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: count WAIT_CYCLES cycles, then go to ACCESS.
  - ACCESS: issue the memory operation for the first word.
  - BEAT2: fetch only; read `addr+1`.
  - ACK: `ready_bus`=1 for exactly this cycle. Go to RELEASE.
  - RELEASE: wait for `cs_biu`=0, then return to IDLE. This is a four-phase handshake: a `cs_biu` held high after the ack never retriggers.
- Memory index is the low log2(DEPTH) bits of the address; out-of-range addresses wrap. A fetch at DEPTH-1 reads its second word from index 0.
- A write commits to memory at the ACCESS edge. `rdata` and `ir` are not altered by a write.
- Data read loads `rdata` on the edge entering ACK. Fetch loads `ir` on the edge entering ACK. The other output holds its value.
- Reserved `sel_biu`: same wait as a data read, no memory access, `err`=1 in ACK, `rdata` and `ir` unchanged.
- `err` is 0 in every cycle where `ready_bus` is 0.
- Changes on `addr`, `sel_biu` or `wdata` after accept are ignored.

## Timing
- Accept edge A is the edge where the state is IDLE and `cs_biu` is 1.
- `ready_bus` is high in the cycle after edge:
  - data read, write or reserved: A+2+WAIT_CYCLES;
  - fetch: A+3+WAIT_CYCLES.
- With WAIT_CYCLES=0, a data read acks 2 cycles after accept and a fetch 3 cycles after accept.
- Minimum spacing between two accepts is ack cycle + RELEASE cycle + one IDLE cycle with `cs_biu` low.
- Reset values:
  - state IDLE, wait counter 0;
  - `ready_bus` 0, `err` 0;
  - `rdata` 0, `ir` 0.
- Memory contents are not cleared by reset.
- Reset mid-operation aborts the transaction and no ack is ever produced. A write is in memory only if its ACCESS edge occurred before reset asserted.
- `cs_biu` high at reset release: it is accepted on the first clock edge after release.

## Structure
- Shared package `bus_pkg`:
  - `sel_biu` encodings: SEL_FETCH, SEL_RD, SEL_WR, SEL_RSV;
  - responder state enum;
  - a WORD_W=16 constant, so the BIU and this block stay consistent.
- One sub-module, `mem_array`: single-port synchronous RAM, DEPTH x 16, one read or write per cycle, registered read data. The FSM and wait counter live in `bus_mem_responder`.

## Test plan
- Write then read. Preload nothing, WAIT_CYCLES=2, write 16'hBEEF to addr 5, release `cs_biu`, then data-read addr 5.
  - Required: `rdata`=16'hBEEF.
  - Required: `ready_bus` high exactly in the cycle after edge A+4 for each transaction.
- Fetch with wrap. Write 16'h1234 to addr DEPTH-1 and 16'h5678 to addr 0, then fetch addr DEPTH-1.
  - Required: `ir`=32'h12345678 and `rdata` unchanged.
- Zero-wait latency. WAIT_CYCLES=0, data read and fetch back-to-back.
  - Required: ack 2 and 3 cycles after their accepts respectively.
  - Required: the second accept happens no earlier than the first IDLE cycle with `cs_biu` low.
- Held strobe. Keep `cs_biu`=1 for 10 cycles after the ack.
  - Required: exactly one `ready_bus` pulse, and the state stays in RELEASE until `cs_biu` drops.
- Reserved op. `sel_biu`=11 at addr 3 after writing 16'hAAAA to addr 3.
  - Required: `ready_bus`=1 and `err`=1 in the same cycle.
  - Required: a subsequent read of addr 3 returns 16'hAAAA.
- Reset mid-transaction. Assert `reset`=0 during WAIT of a write of 16'h0F0F to addr 7 (old value 16'h1111).
  - Required: `ready_bus` and `err` are 0 immediately, with no ack after release.
  - Required: a subsequent read of addr 7 returns 16'h1111.
